// File: rtl/ascon_tag_extract.sv
// Ascon finalization tag extraction: forms T = {x3,x4} ^ K, then streams it as two
// 64-bit words (generate) or checks it against a received tag (verify).
module ascon_tag_extract #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [63:0]  state_x3,
    input  logic [63:0]  state_x4,
    input  logic [127:0] key,
    input  logic [127:0] expected_tag,
    output logic [63:0]  tag_data,
    output logic         tag_valid,
    output logic         tag_last,
    input  logic         tag_ready,
    output logic         busy,
    output logic         done,
    output logic         auth_ok,
    output logic         auth_fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_reg, state_next;
    logic [127:0] tag_reg, tag_next;
    logic [127:0] exp_reg, exp_next;
    logic         auth_ok_reg, auth_ok_next;
    logic         auth_fail_reg, auth_fail_next;
    logic [127:0] fresh_tag;
    logic [63:0]  tag_word [2];

    assign fresh_tag = {state_x3 ^ key[127:64], state_x4 ^ key[63:0]};

    // tag_word[0] is the first word on the stream, tag_word[1] the last
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_word
            localparam int SRC = HI_FIRST ? (1 - gi) : gi;
            assign tag_word[gi] = tag_reg[SRC*64 +: 64];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tag_reg       <= '0;
            exp_reg       <= '0;
            auth_ok_reg   <= 1'b0;
            auth_fail_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tag_reg       <= tag_next;
            exp_reg       <= exp_next;
            auth_ok_reg   <= auth_ok_next;
            auth_fail_reg <= auth_fail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = mode ? CMP : SEND0;
            SEND0:   if (tag_ready) state_next = SEND1;
            SEND1:   if (tag_ready) state_next = DONE;
            CMP:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Secrets live only from the accepted start until DONE, where they are wiped
    always_comb begin
        tag_next       = tag_reg;
        exp_next       = exp_reg;
        auth_ok_next   = auth_ok_reg;
        auth_fail_next = auth_fail_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    tag_next       = fresh_tag;
                    exp_next       = mode ? expected_tag : '0;
                    auth_ok_next   = 1'b0;
                    auth_fail_next = 1'b0;
                end
            end
            CMP: begin
                auth_ok_next   = (tag_reg == exp_reg);
                auth_fail_next = (tag_reg != exp_reg);
            end
            DONE: begin
                tag_next = '0;
                exp_next = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        tag_data  = '0;
        tag_valid = 1'b0;
        tag_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            SEND0: begin
                tag_valid = 1'b1;
                tag_data  = tag_word[0];
            end
            SEND1: begin
                tag_valid = 1'b1;
                tag_last  = 1'b1;
                tag_data  = tag_word[1];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign auth_ok   = auth_ok_reg;
    assign auth_fail = auth_fail_reg;

endmodule

// File: tb/tb_ascon_tag_extract.sv
// Bench for ascon_tag_extract: both word orders run side by side against a
// transaction-level model (tag formula, word order, sticky auth flags).
module tb_ascon_tag_extract;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, mode, tag_ready;
    logic [63:0]  x3, x4;
    logic [127:0] key, exp_tag;

    logic [63:0] td1, td0;
    logic        tv1, tl1, b1, d1, ok1, f1;
    logic        tv0, tl0, b0, d0, ok0, f0;

    always #5 clk = ~clk;

    ascon_tag_extract #(.HI_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .state_x3(x3), .state_x4(x4), .key(key), .expected_tag(exp_tag),
        .tag_data(td1), .tag_valid(tv1), .tag_last(tl1), .tag_ready(tag_ready),
        .busy(b1), .done(d1), .auth_ok(ok1), .auth_fail(f1)
    );

    ascon_tag_extract #(.HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .state_x3(x3), .state_x4(x4), .key(key), .expected_tag(exp_tag),
        .tag_data(td0), .tag_valid(tv0), .tag_last(tl0), .tag_ready(tag_ready),
        .busy(b0), .done(d0), .auth_ok(ok0), .auth_fail(f0)
    );

    typedef struct {
        bit           mode;
        logic [63:0]  x3;
        logic [63:0]  x4;
        logic [127:0] key;
        logic [127:0] exp;
        int           stall0;
        int           stall1;
        bit           inject;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] m_tag;
    bit           m_ok, m_fail;

    task automatic expect_state(input string name, input bit v, input bit l,
                                input int widx, input bit b, input bit d);
        logic [63:0] w1, w0;
        logic [69:0] e1, e0, a1, a0;
        w1 = !v ? 64'd0 : (widx == 0 ? m_tag[127:64] : m_tag[63:0]);
        w0 = !v ? 64'd0 : (widx == 0 ? m_tag[63:0] : m_tag[127:64]);
        e1 = {v, l, b, d, m_ok, m_fail, w1};
        e0 = {v, l, b, d, m_ok, m_fail, w0};
        a1 = {tv1, tl1, b1, d1, ok1, f1, td1};
        a0 = {tv0, tl0, b0, d0, ok0, f0, td0};
        n_cmp++;
        if (a1 !== e1) begin
            n_err++;
            $display("FAIL %s hi_first=1 got {v,l,b,d,ok,f,data}=%h want=%h", name, a1, e1);
        end
        n_cmp++;
        if (a0 !== e0) begin
            n_err++;
            $display("FAIL %s hi_first=0 got {v,l,b,d,ok,f,data}=%h want=%h", name, a0, e0);
        end
    endtask

    // Called at posedge+1 with the DUTs in IDLE; returns the same way.
    task automatic do_op(input vec_t v);
        int s;
        mode      = v.mode;
        x3        = v.x3;
        x4        = v.x4;
        key       = v.key;
        exp_tag   = v.exp;
        start     = 1'b1;
        tag_ready = 1'($urandom_range(0, 1));
        m_tag     = {v.x3 ^ v.key[127:64], v.x4 ^ v.key[63:0]};
        m_ok      = 1'b0;
        m_fail    = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        x3      = {$urandom, $urandom};
        x4      = {$urandom, $urandom};
        key     = {$urandom, $urandom, $urandom, $urandom};
        exp_tag = {$urandom, $urandom, $urandom, $urandom};
        mode    = 1'($urandom_range(0, 1));
        if (!v.mode) begin
            for (int w = 0; w < 2; w++) begin
                s = (w == 0) ? v.stall0 : v.stall1;
                for (int c = 0; c <= s; c++) begin
                    tag_ready = (c == s);
                    start     = (w == 1 && v.inject && c == 0);
                    expect_state(w == 0 ? "send_word0" : "send_word1", 1'b1, w == 1, w, 1'b1, 1'b0);
                    @(posedge clk); #1;
                end
            end
            start     = v.inject;
            tag_ready = 1'($urandom_range(0, 1));
            expect_state("done_gen", 1'b0, 1'b0, 0, 1'b1, 1'b1);
            @(posedge clk); #1;
            start = 1'b0;
            expect_state("idle_gen", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end else begin
            tag_ready = 1'b1;
            start     = v.inject;
            expect_state("cmp", 1'b0, 1'b0, 0, 1'b1, 1'b0);
            @(posedge clk); #1;
            m_ok   = (m_tag == v.exp);
            m_fail = !m_ok;
            start  = v.inject;
            expect_state("done_ver", 1'b0, 1'b0, 0, 1'b1, 1'b1);
            @(posedge clk); #1;
            start = 1'b0;
            expect_state("idle_ver", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                   {64'hFFFFFFFFFFFFFFFF, 64'h0}, 128'h0, 0, 0, 1'b0};
        tbl[1] = '{1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                   {64'hFFFFFFFFFFFFFFFF, 64'h0}, 128'h0, 3, 0, 1'b0};
        tbl[2] = '{1'b1, 64'h1111111111111111, 64'h1111111111111111,
                   128'h0, {2{64'h1111111111111111}}, 0, 0, 1'b0};
        tbl[3] = '{1'b1, 64'h1111111111111111, 64'h1111111111111111,
                   128'h0, {2{64'h1111111111111111}} ^ 128'h1, 0, 0, 1'b0};
        tbl[4] = '{1'b0, 64'hA5A5A5A55A5A5A5A, 64'h0F0F0F0FF0F0F0F0,
                   {64'h1234, 64'h5678}, 128'h0, 1, 2, 1'b1};
        tbl[5] = '{1'b1, 64'hDEADBEEFCAFEF00D, 64'h0,
                   {64'hDEADBEEFCAFEF00D, 64'h1}, {64'h0, 64'h1}, 0, 0, 1'b1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; tag_ready = 1'b0;
        x3 = '0; x4 = '0; key = '0; exp_tag = '0;
        m_tag = '0; m_ok = 1'b0; m_fail = 1'b0;
        #3;
        expect_state("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) do_op(tbl[i]);

        // Sticky auth_fail survives idle but not reset
        do_op(tbl[3]);
        @(posedge clk); #1;
        expect_state("sticky_fail", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_fail = 1'b0;
        expect_state("reset_clears_auth", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in SEND1 with downstream stalled
        mode = 1'b0; x3 = 64'h0123456789ABCDEF; x4 = 64'hFEDCBA9876543210;
        key = {64'hFFFFFFFFFFFFFFFF, 64'h0}; start = 1'b1; tag_ready = 1'b1;
        m_tag = {x3 ^ key[127:64], x4 ^ key[63:0]};
        @(posedge clk); #1;
        start = 1'b0;
        expect_state("pre_rst_word0", 1'b1, 1'b0, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        tag_ready = 1'b0;
        expect_state("pre_rst_word1", 1'b1, 1'b1, 1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("rst_in_send1", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        expect_state("rst_held", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        do_op(tbl[0]);

        // Reset in CMP
        mode = 1'b1; start = 1'b1; exp_tag = '0; key = '0; x3 = '0; x4 = '0;
        @(posedge clk); #1;
        start = 1'b0;
        m_tag = '0;
        expect_state("pre_rst_cmp", 1'b0, 1'b0, 0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("rst_in_cmp", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) begin
            rv.mode   = 1'($urandom_range(0, 1));
            rv.x3     = {$urandom, $urandom};
            rv.x4     = {$urandom, $urandom};
            rv.key    = {$urandom, $urandom, $urandom, $urandom};
            rv.stall0 = $urandom_range(0, 3);
            rv.stall1 = $urandom_range(0, 3);
            rv.inject = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       rv.exp = {rv.x3 ^ rv.key[127:64], rv.x4 ^ rv.key[63:0]};
                1:       rv.exp = {rv.x3 ^ rv.key[127:64], rv.x4 ^ rv.key[63:0]}
                                  ^ (128'h1 << $urandom_range(0, 127));
                default: rv.exp = {$urandom, $urandom, $urandom, $urandom};
            endcase
            do_op(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ascon_tag_extract.md
ASCON_TAG_EXTRACT -- requirements
Module: ascon_tag_extract

Interface
REQ-001 Parameter: HI_FIRST, default 1, 1 = stream tag[127:64] first, 0 = tag[63:0] first.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 mode  input  1  0 = generate (stream tag), 1 = verify (compare tag); sampled with start.
REQ-006 state_x3  input  64  state word x3 from the state register.
REQ-007 state_x4  input  64  state word x4 from the state register.
REQ-008 key  input  128  cipher key K.
REQ-009 expected_tag  input  128  received tag for verify mode.
REQ-010 tag_data  output  64  streamed tag word.
REQ-011 tag_valid  output  1  tag_data valid.
REQ-012 tag_last  output  1  marks the second (final) tag word.
REQ-013 tag_ready  input  1  downstream accepts when high with tag_valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 auth_ok  output  1  verify passed; sticky until next accepted start or reset.
REQ-017 auth_fail  output  1  verify failed; sticky until next accepted start or reset.

Function
REQ-018 Tag SHALL be T = {state_x3 ^ key[127:64], state_x4 ^ key[63:0]}, computed from inputs present in the start cycle and captured into an internal 128-bit register at that edge.
REQ-019 In verify mode, expected_tag SHALL be captured at the same edge.
REQ-020 FSM states: IDLE, SEND0, SEND1, CMP, DONE.
REQ-021 IDLE + start + mode=0 -> SEND0; IDLE + start + mode=1 -> CMP; an accepted start clears auth_ok and auth_fail.
REQ-022 start while busy SHALL be ignored, with no effect on state, captured data or outputs.
REQ-023 SEND0: tag_valid=1, tag_last=0, tag_data = first word per HI_FIRST; on tag_valid&tag_ready -> SEND1.
REQ-024 SEND1: tag_valid=1, tag_last=1, tag_data = second word; on handshake -> DONE.
REQ-025 tag_data and tag_last SHALL stay stable while tag_valid=1 and tag_ready=0; no timeout.
REQ-026 tag_valid SHALL be high in the cycle after the start edge, i.e. latency 1 clock.
REQ-027 Back-to-back ready SHALL transfer both words in 2 consecutive cycles.
REQ-028 CMP (one cycle): full 128-bit equality of captured T vs captured expected_tag; auth_ok or auth_fail set at exit edge (exactly one of them) -> DONE.
REQ-029 Verify mode SHALL never assert tag_valid.
REQ-030 DONE (one cycle): done=1, internal tag and expected registers zeroized -> IDLE.
REQ-031 start arriving during DONE SHALL be ignored; a start is accepted no earlier than the following cycle, in IDLE.
REQ-032 tag_data SHALL drive 0 whenever tag_valid=0.
REQ-033 Changes on state_x3, state_x4, key or expected_tag after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-034 rst_n low, at any time including mid-stream or in CMP, SHALL immediately force IDLE, zero internal registers, and drive tag_data, tag_valid, tag_last, busy, done, auth_ok and auth_fail to 0.
REQ-035 After rst_n deasserts, the first start SHALL be accepted on the next clock edge.

Verification
REQ-036 Generate, HI_FIRST=1: x3=0123456789ABCDEF, x4=FEDCBA9876543210, key={FFFFFFFFFFFFFFFF,0000000000000000}, tag_ready=1 -> tag_valid one clock after start, words FEDCBA9876543210 then FEDCBA9876543210 (last=1), done one clock later.
REQ-037 Backpressure: same stimulus, tag_ready low 3 cycles in SEND0 -> tag_data held, no word lost or duplicated; inputs changed after start -> output unchanged.
REQ-038 Verify match: x3=x4=1111111111111111, key=0, expected_tag=1111...1111 (128b) -> done and auth_ok=1 two clocks after start, auth_fail=0, tag_valid never high.
REQ-039 Verify mismatch: expected_tag differs only in bit 0 -> auth_fail=1, auth_ok=0; next accepted start clears both.
REQ-040 start pulsed during SEND1 and during DONE -> ignored; HI_FIRST=0 run emits tag[63:0] first.
REQ-041 rst_n asserted in SEND1 while tag_ready=0 -> all outputs 0 immediately; new start after release completes normally.
